// File: rtl/sobel_window_gen_if.sv
// Avalon-ST pixel sink plus 3x3 window source for sobel_window_gen.
// slave = the window generator's view, master = the driving/consuming side.
interface sobel_window_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]   snk_data_i;
  logic                snk_valid_i;
  logic                snk_sop_i;
  logic                snk_eop_i;
  logic                snk_ready_o;
  logic [9*DATA_W-1:0] win_o;
  logic                win_valid_o;
  logic                win_ready_i;
  logic                win_sop_o;
  logic                win_eop_o;

  modport slave (
    input  snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, win_ready_i,
    output snk_ready_o, win_o, win_valid_o, win_sop_o, win_eop_o
  );

  modport master (
    output snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, win_ready_i,
    input  snk_ready_o, win_o, win_valid_o, win_sop_o, win_eop_o
  );
endinterface

// File: rtl/sobel_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream using two line buffers.
// Optional: define SOBEL_WIN_SOP_RESYNC_EN to let a mid-frame sop restart the frame.
module sobel_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 320
) (
  input logic               clk_i,
  input logic               rst_ni,
  sobel_window_gen_if.slave bus
);
  localparam int COL_W = $clog2(IMG_W);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

  state_t                  r_state, w_state_nxt;
  logic [COL_W-1:0]        r_col, w_col_nxt, w_wcol;
  logic [11:0]             r_row, w_row_nxt;
  logic [DATA_W-1:0]       r_lb0 [IMG_W];  // row r-2
  logic [DATA_W-1:0]       r_lb1 [IMG_W];  // row r-1
  logic [2:0][DATA_W-1:0]  r_m1, r_m2, w_ncol;
  logic [8:0][DATA_W-1:0]  r_win;
  logic                    r_vld, r_sop, r_eop;
  logic                    w_ready, w_acc, w_start, w_data, w_store;
  logic                    w_win_pos, w_load, w_last_col;

  assign w_ready = !r_vld || bus.win_ready_i;
  assign w_acc   = bus.snk_valid_i && w_ready;

`ifdef SOBEL_WIN_SOP_RESYNC_EN
  assign w_start = w_acc && bus.snk_sop_i;
`else
  assign w_start = w_acc && bus.snk_sop_i && (r_state == S_IDLE);
`endif

  assign w_data     = w_acc && (r_state != S_IDLE) && !w_start;
  assign w_store    = w_start || w_data;
  assign w_wcol     = w_start ? '0 : r_col;
  assign w_last_col = (r_col == COL_W'(IMG_W - 1));
  assign w_win_pos  = (r_row >= 12'd2) && (r_col >= COL_W'(2));
  assign w_load     = w_data && w_win_pos;

  // Column entering the window, index 0 = oldest row
  assign w_ncol[0] = r_lb0[w_wcol];
  assign w_ncol[1] = r_lb1[w_wcol];
  assign w_ncol[2] = bus.snk_data_i;

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    if (w_start) begin
      w_state_nxt = S_FILL;
      w_col_nxt   = COL_W'(1);
      w_row_nxt   = '0;
    end else if (w_data) begin
      if (w_last_col) begin
        w_col_nxt = '0;
        w_row_nxt = (r_row == 12'hFFF) ? r_row : r_row + 12'd1;
      end else begin
        w_col_nxt = r_col + COL_W'(1);
      end
      w_state_nxt = (w_win_pos && !w_last_col) ? S_STREAM : S_FILL;
    end
    // Any accepted eop inside a frame closes it, whatever the position
    if (w_store && bus.snk_eop_i) begin
      w_state_nxt = S_IDLE;
      w_col_nxt   = '0;
      w_row_nxt   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_store) begin
      r_lb0[w_wcol] <= r_lb1[w_wcol];
      r_lb1[w_wcol] <= bus.snk_data_i;
      r_m2          <= r_m1;
      r_m1          <= w_ncol;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_win <= '0;
      r_vld <= 1'b0;
      r_sop <= 1'b0;
      r_eop <= 1'b0;
    end else if (w_load) begin
      for (int rr = 0; rr < 3; rr++) begin
        r_win[rr*3]   <= r_m2[rr];
        r_win[rr*3+1] <= r_m1[rr];
        r_win[rr*3+2] <= w_ncol[rr];
      end
      r_vld <= 1'b1;
      r_sop <= (r_row == 12'd2) && (r_col == COL_W'(2));
      r_eop <= bus.snk_eop_i;
    end else if (bus.win_ready_i) begin
      r_vld <= 1'b0;
    end
  end

  assign bus.snk_ready_o = w_ready;
  assign bus.win_o       = r_win;
  assign bus.win_valid_o = r_vld;
  assign bus.win_sop_o   = r_sop;
  assign bus.win_eop_o   = r_eop;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: table-driven 4x4 frame, hand-written corner sequences,
// randomized frames checked against an image-array reference model.
module tb_sobel_window_gen;
  localparam int DW = 8;
  localparam int IW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_window_gen_if #(.DATA_W(DW)) bus();
  sobel_window_gen #(.DATA_W(DW), .IMG_W(IW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  int n_win    = 0;
  bit rnd_mode    = 1'b0;
  bit ready_force = 1'b1;
  bit r_rand      = 1'b1;

  always_comb bus.win_ready_i = rnd_mode ? r_rand : ready_force;
  always @(negedge clk) r_rand = 1'($urandom_range(0, 1));

  typedef struct {
    logic [71:0] w;
    bit          sop;
    bit          eop;
  } win_t;

  typedef struct {
    logic [7:0]  pix;
    bit          sop;
    bit          eop;
    bit          has_win;
    logic [71:0] w;
    bit          wsop;
    bit          weop;
  } vec_t;

  win_t       exp_q[$];
  win_t       mx;
  bit         in_frame = 1'b0;
  int         idx = 0;
  logic [7:0] img [0:63][0:IW-1];

  task automatic chk(string name, logic [73:0] act, logic [73:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk9(int a0, int a1, int a2, int a3, int a4,
                                      int a5, int a6, int a7, int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Reference: place each frame pixel in an image array by raster index and
  // cut the 3x3 neighbourhood ending at it.
  task automatic model_accept(logic [7:0] d, bit s, bit e);
    int r, c;
    bit start;
`ifdef SOBEL_WIN_SOP_RESYNC_EN
    start = s;
`else
    start = s && !in_frame;
`endif
    if (!in_frame && !start) return;
    if (start) begin
      idx      = 0;
      in_frame = 1'b1;
    end
    r = idx / IW;
    c = idx % IW;
    if (r < 64) begin
      img[r][c] = d;
      if (r >= 2 && c >= 2) begin
        win_t x;
        for (int k = 0; k < 9; k++) x.w[k*8 +: 8] = img[r-2+k/3][c-2+k%3];
        x.sop = (r == 2 && c == 2);
        x.eop = e;
        exp_q.push_back(x);
      end
    end
    idx++;
    if (e) in_frame = 1'b0;
  endtask

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      exp_q.delete();
      in_frame = 1'b0;
    end else begin
      if (bus.win_valid_o && bus.win_ready_i) begin
        n_win++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_window: got %h, no window expected", bus.win_o);
        end else begin
          mx = exp_q.pop_front();
          chk("window", {bus.win_eop_o, bus.win_sop_o, bus.win_o}, {mx.eop, mx.sop, mx.w});
        end
      end
      if (bus.snk_valid_i && bus.snk_ready_o)
        model_accept(bus.snk_data_i, bus.snk_sop_i, bus.snk_eop_i);
    end
  end

  task automatic send(logic [7:0] d, bit s, bit e);
    int n = 0;
    if (rnd_mode) repeat ($urandom_range(0, 1)) @(negedge clk);
    bus.snk_data_i  = d;
    bus.snk_sop_i   = s;
    bus.snk_eop_i   = e;
    bus.snk_valid_i = 1'b1;
    #2;
    while (!bus.snk_ready_o && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: snk_ready_o 0 for 200 cycles, required 1");
    end
    @(negedge clk);
    bus.snk_valid_i = 1'b0;
    bus.snk_sop_i   = 1'b0;
    bus.snk_eop_i   = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 16; i++) send(8'(i), i == 0, i == 15);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  vec_t tbl [16];
  int   base;

  initial begin
    for (int i = 0; i < 16; i++)
      tbl[i] = '{pix: 8'(i), sop: (i == 0), eop: (i == 15), has_win: 1'b0,
                 w: '0, wsop: 1'b0, weop: 1'b0};
    tbl[10].has_win = 1'b1; tbl[10].w = mk9(0, 1, 2, 4, 5, 6, 8, 9, 10);    tbl[10].wsop = 1'b1;
    tbl[11].has_win = 1'b1; tbl[11].w = mk9(1, 2, 3, 5, 6, 7, 9, 10, 11);
    tbl[14].has_win = 1'b1; tbl[14].w = mk9(4, 5, 6, 8, 9, 10, 12, 13, 14);
    tbl[15].has_win = 1'b1; tbl[15].w = mk9(5, 6, 7, 9, 10, 11, 13, 14, 15); tbl[15].weop = 1'b1;

    bus.snk_data_i  = '0;
    bus.snk_valid_i = 1'b0;
    bus.snk_sop_i   = 1'b0;
    bus.snk_eop_i   = 1'b0;

    #3;
    chk("rst_win_valid", 74'(bus.win_valid_o), 74'(0));
    chk("rst_win_o", 74'(bus.win_o), 74'(0));
    chk("rst_sop_eop", 74'({bus.win_sop_o, bus.win_eop_o}), 74'(0));
    chk("rst_snk_ready", 74'(bus.snk_ready_o), 74'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_snk_ready", 74'(bus.snk_ready_o), 74'(1));

    // Basic 4x4 frame, window checked one cycle after each pixel
    base = n_win;
    for (int i = 0; i < 16; i++) begin
      send(tbl[i].pix, tbl[i].sop, tbl[i].eop);
      #1;
      chk("tbl_valid", 74'(bus.win_valid_o), 74'(tbl[i].has_win));
      if (tbl[i].has_win)
        chk("tbl_window", {bus.win_eop_o, bus.win_sop_o, bus.win_o},
            {tbl[i].weop, tbl[i].wsop, tbl[i].w});
    end
    drain();
    chk("frame_count", 74'(n_win - base), 74'(4));

    // Downstream stall of 3 cycles on the first window
    base = n_win;
    fork
      send_frame();
      begin
        logic [71:0] held;
        int n = 0;
        do begin
          @(negedge clk);
          #1;
          n++;
        end while (!bus.win_valid_o && n < 100);
        chk("stall_window_seen", 74'(bus.win_valid_o), 74'(1));
        ready_force = 1'b0;
        held = bus.win_o;
        for (int c = 0; c < 3; c++) begin
          #1;
          chk("stall_snk_ready", 74'(bus.snk_ready_o), 74'(0));
          chk("stall_win_hold", 74'(bus.win_o), 74'(held));
          @(negedge clk);
          #1;
        end
        ready_force = 1'b1;
      end
    join
    drain();
    chk("stall_count", 74'(n_win - base), 74'(4));

    // Stray pixels before sop are dropped
    base = n_win;
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send_frame();
    drain();
    chk("stray_count", 74'(n_win - base), 74'(4));

    // Reset in the middle of a frame
    for (int i = 0; i < 10; i++) send(8'(8'h60 + i), i == 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 74'(bus.win_valid_o), 74'(0));
    chk("midrst_win_o", 74'(bus.win_o), 74'(0));
    chk("midrst_snk_ready", 74'(bus.snk_ready_o), 74'(1));
    @(negedge clk);
    rst_n = 1'b1;
    base = n_win;
    send_frame();
    drain();
    chk("midrst_count", 74'(n_win - base), 74'(4));

    // sop arriving inside a frame
    base = n_win;
    for (int i = 0; i < 6; i++) send(8'(8'h40 + i), i == 0, 1'b0);
    send_frame();
    drain();
`ifdef SOBEL_WIN_SOP_RESYNC_EN
    chk("resync_count", 74'(n_win - base), 74'(4));
`else
    chk("resync_count", 74'(n_win - base), 74'(6));
`endif

    // One-pixel frame, then confirm the FSM is idle again
    base = n_win;
    send(8'h55, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("onepix_valid", 74'(bus.win_valid_o), 74'(0));
    chk("onepix_count", 74'(n_win - base), 74'(0));
    send(8'h77, 1'b0, 1'b0);
    send_frame();
    drain();
    chk("onepix_next_count", 74'(n_win - base), 74'(4));

    // Randomized frames with random backpressure, gaps and early eop
    rnd_mode = 1'b1;
    for (int f = 0; f < 10; f++) begin
      int ng, rows, last;
      ng   = $urandom_range(0, 2);
      rows = $urandom_range(2, 5);
      last = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rows*IW - 1) : rows*IW - 1;
      for (int g = 0; g < ng; g++) send(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      for (int i = 0; i <= last; i++) send(8'($urandom), i == 0, i == last);
    end
    drain();
    rnd_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 74'(exp_q.size()), 74'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
